// File: rtl/cpu_hazard_ctrl_pkg.sv
// rtl/cpu_hazard_ctrl_pkg.sv - shared types, forwarding codes and source-pick helper for the hazard scheduler
package cpu_hazard_ctrl_pkg;

   localparam logic [1:0] FWD_REGFILE = 2'd0;
   localparam logic [1:0] FWD_EX      = 2'd1;
   localparam logic [1:0] FWD_MEM     = 2'd2;
   localparam logic [1:0] FWD_WB      = 2'd3;

   typedef enum logic [1:0] {RUN, HOLD, DRAIN} hz_state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] num;
      logic       load;
   } sb_entry_t;

   // hit[0]=EX, hit[1]=MEM, hit[2]=WB; the youngest producer wins, a load in EX has no result yet
   function automatic logic [1:0] fwd_pick(input logic [2:0] hit, input logic ex_load);
      if (hit[0] && !ex_load) return FWD_EX;
      if (hit[1])             return FWD_MEM;
      if (hit[2])             return FWD_WB;
      return FWD_REGFILE;
   endfunction

endpackage

// File: rtl/cpu_hazard_ctrl_if.sv
// rtl/cpu_hazard_ctrl_if.sv - ID-stage read ports, EX/MEM status and hazard controls
interface cpu_hazard_ctrl_if;
   logic [4:0] rd1_num;
   logic [4:0] rd2_num;
   logic       id_dest_en;
   logic [4:0] id_dest_num;
   logic       id_dest_load;
   logic       redirect;
   logic       mem_busy;
   logic       stall;
   logic       freeze;
   logic       id_clr;
   logic [1:0] fwd1_sel;
   logic [1:0] fwd2_sel;

   modport master (
      output rd1_num, rd2_num, id_dest_en, id_dest_num, id_dest_load, redirect, mem_busy,
      input  stall, freeze, id_clr, fwd1_sel, fwd2_sel
   );

   modport slave (
      input  rd1_num, rd2_num, id_dest_en, id_dest_num, id_dest_load, redirect, mem_busy,
      output stall, freeze, id_clr, fwd1_sel, fwd2_sel
   );
endinterface

// File: rtl/cpu_hazard_ctrl_hz_match.sv
// rtl/cpu_hazard_ctrl_hz_match.sv - compares one scoreboard entry against one read register number
module cpu_hazard_ctrl_hz_match
   import cpu_hazard_ctrl_pkg::*;
(
   input  sb_entry_t  entry,
   input  logic [4:0] num,
   output logic       hit,
   output logic       hit_load
);
   // $0 is hardwired, so it never matches a pending writer
   assign hit      = entry.valid && (num != 5'd0) && (entry.num == num);
   assign hit_load = hit && entry.load;
endmodule

// File: rtl/cpu_hazard_ctrl.sv
// rtl/cpu_hazard_ctrl.sv - ID-stage hazard scheduler: EX/MEM/WB write scoreboard, operand forwarding,
// load-use stall, memory-busy freeze and post-redirect ID flush
module cpu_hazard_ctrl
   import cpu_hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 3
) (
   input logic              clk,
   input logic              clr_n,
   cpu_hazard_ctrl_if.slave hz
);
   hz_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   sb_entry_t        sb [3];
   sb_entry_t        ex_nxt;
   logic [4:0]       rd_num [2];
   logic [2:0]       hit [2];
   logic [2:0]       hit_load [2];
   logic             load_use;
   logic             accept;
   logic             unused_hit_load;

   assign rd_num[0] = hz.rd1_num;
   assign rd_num[1] = hz.rd2_num;

   for (genvar p = 0; p < 2; p++) begin : g_port
      for (genvar s = 0; s < 3; s++) begin : g_stage
         cpu_hazard_ctrl_hz_match u_match (
            .entry    (sb[s]),
            .num      (rd_num[p]),
            .hit      (hit[p][s]),
            .hit_load (hit_load[p][s])
         );
      end
   end

   // only a load still in EX is unforwardable; loads in MEM/WB forward like ALU results
   assign unused_hit_load = ^{hit_load[0][2:1], hit_load[1][2:1]};
   assign load_use        = hit_load[0][0] | hit_load[1][0];

   // a redirect held through HOLD is taken on the first cycle memory is free
   assign accept      = (state != DRAIN) && hz.redirect && !hz.mem_busy;
   assign hz.freeze   = hz.mem_busy;
   assign hz.stall    = hz.mem_busy | load_use;
   assign hz.id_clr   = accept || (state == DRAIN);
   assign hz.fwd1_sel = fwd_pick(hit[0], hit_load[0][0]);
   assign hz.fwd2_sel = fwd_pick(hit[1], hit_load[1][0]);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RUN, HOLD: begin
            if (hz.mem_busy) begin
               state_nxt = HOLD;
            end else if (hz.redirect) begin
               state_nxt = DRAIN;
               cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
            end else begin
               state_nxt = RUN;
            end
         end
         DRAIN: begin
            if (!hz.mem_busy) begin
               if (cnt == '0) state_nxt = RUN;
               else           cnt_nxt   = cnt - 1'b1;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      ex_nxt.valid = hz.id_dest_en && (hz.id_dest_num != 5'd0) && !hz.stall && !hz.id_clr;
      ex_nxt.num   = hz.id_dest_num;
      ex_nxt.load  = hz.id_dest_load;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state <= RUN;
         cnt   <= '0;
         sb[0] <= '0;
         sb[1] <= '0;
         sb[2] <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (hz.mem_busy) begin
            // EX/MEM hold; the WB writer has reached the regfile
            sb[2] <= '0;
         end else begin
            sb[0] <= ex_nxt;
            sb[1] <= sb[0];
            sb[2] <= sb[1];
         end
      end
   end
endmodule
